// File: rtl/sipo_pkg.sv
// Shared types and helpers for the SIPO capture register.
// Counter width, FSM states and default bit order.
package sipo_pkg;

  localparam int WIDTH_DEFAULT     = 8;
  localparam bit MSB_FIRST_DEFAULT = 1'b1;

  function automatic int cnt_width(input int w);
    return ($clog2(w) < 1) ? 1 : $clog2(w);
  endfunction

  typedef logic [cnt_width(WIDTH_DEFAULT)-1:0] cnt_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } st_t;

endpackage

// File: rtl/sipo_bit_counter.sv
// Bit counter for the SIPO capture register.
// Tracks word position, handles sync and flags completion.
module sipo_bit_counter
  import sipo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_shift_en,
  input  logic                        i_sync,
  output logic [cnt_width(WIDTH)-1:0] o_cnt,
  output logic                        o_done,
  output logic                        o_busy
);

  localparam int CW = cnt_width(WIDTH);
  typedef logic [CW-1:0] lcnt_t;
  localparam lcnt_t LAST = lcnt_t'(WIDTH - 1);

  lcnt_t r_cnt;
  st_t   r_st;
  lcnt_t w_eff;
  lcnt_t w_cnt_nxt;
  st_t   w_st_nxt;
  logic  w_done;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_st  <= ST_IDLE;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_st  <= w_st_nxt;
    end
  end

  // A sync with a shift makes the current bit position zero.
  always_comb begin
    w_eff     = (i_sync && i_shift_en) ? '0 : r_cnt;
    w_done    = i_shift_en && (w_eff == LAST);
    w_cnt_nxt = r_cnt;
    if (i_shift_en)
      w_cnt_nxt = w_done ? '0 : w_eff + lcnt_t'(1);
    else if (i_sync)
      w_cnt_nxt = '0;
    w_st_nxt = (w_cnt_nxt != '0) ? ST_RECV : ST_IDLE;
  end

  assign o_cnt  = r_cnt;
  assign o_done = w_done;
  assign o_busy = (r_st == ST_RECV);

endmodule

// File: rtl/sipo_capture_register.sv
// Serial-in parallel-out capture register with valid/ack
// handoff, sticky overrun and a registered cascade output.
module sipo_capture_register
  import sipo_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEFAULT,
  parameter bit MSB_FIRST = MSB_FIRST_DEFAULT
) (
  input  logic             cp,
  input  logic             mr_n,
  input  logic             ds,
  input  logic             shift_en,
  input  logic             sync,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  input  logic             q_ack,
  output logic             overrun,
  input  logic             clr_ovr,
  output logic             busy,
  output logic             qs
);

  logic [WIDTH-1:0]            r_sreg;
  logic [WIDTH-1:0]            r_q;
  logic                        r_valid;
  logic                        r_ovr;
  logic                        r_qs;
  logic [WIDTH-1:0]            w_sreg_nxt;
  logic                        w_qs_nxt;
  logic [cnt_width(WIDTH)-1:0] w_cnt;
  logic                        w_done;
  logic                        w_busy;
  logic                        w_load;
  logic                        w_drop;

  sipo_bit_counter #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk       (cp),
    .rst_n     (mr_n),
    .i_shift_en(shift_en),
    .i_sync    (sync),
    .o_cnt     (w_cnt),
    .o_done    (w_done),
    .o_busy    (w_busy)
  );

  generate
    if (WIDTH == 1) begin : g_w1
      assign w_sreg_nxt = ds;
      assign w_qs_nxt   = r_sreg[0];
    end else if (MSB_FIRST) begin : g_msb
      assign w_sreg_nxt = {r_sreg[WIDTH-2:0], ds};
      assign w_qs_nxt   = r_sreg[WIDTH-1];
    end else begin : g_lsb
      assign w_sreg_nxt = {ds, r_sreg[WIDTH-1:1]};
      assign w_qs_nxt   = r_sreg[0];
    end
  endgenerate

  // A pending word may be replaced only if it is acked now.
  assign w_load = w_done && (!r_valid || q_ack);
  assign w_drop = w_done && r_valid && !q_ack;

  always_ff @(posedge cp) begin
    if (!mr_n) begin
      r_sreg  <= '0;
      r_q     <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
      r_qs    <= 1'b0;
    end else begin
      if (shift_en) begin
        r_sreg <= w_sreg_nxt;
        r_qs   <= w_qs_nxt;
      end
      if (w_load) begin
        r_q     <= w_sreg_nxt;
        r_valid <= 1'b1;
      end else if (q_ack && !w_done) begin
        r_valid <= 1'b0;
      end
      r_ovr <= w_drop | (r_ovr & ~clr_ovr);
    end
  end

  assign q       = r_q;
  assign q_valid = r_valid;
  assign overrun = r_ovr;
  assign busy    = w_busy;
  assign qs      = r_qs;

  logic w_unused;
  assign w_unused = ^w_cnt;

endmodule

// File: tb/tb_sipo_capture_register.sv
// Directed bench for sipo_capture_register, both bit orders.
// Expected words are hand-computed from the serial streams.
module tb_sipo_capture_register;

  logic       cp = 1'b0;
  logic       mr_n, ds, shift_en, sync, q_ack, clr_ovr;
  logic [7:0] q_m, q_l;
  logic       v_m, v_l, o_m, o_l, b_m, b_l, s_m, s_l;
  int         n_chk = 0;
  int         n_err = 0;

  always #5 cp = ~cp;

  sipo_capture_register #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .cp(cp), .mr_n(mr_n), .ds(ds), .shift_en(shift_en),
    .sync(sync), .q(q_m), .q_valid(v_m), .q_ack(q_ack),
    .overrun(o_m), .clr_ovr(clr_ovr), .busy(b_m), .qs(s_m)
  );

  sipo_capture_register #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .cp(cp), .mr_n(mr_n), .ds(ds), .shift_en(shift_en),
    .sync(sync), .q(q_l), .q_valid(v_l), .q_ack(q_ack),
    .overrun(o_l), .clr_ovr(clr_ovr), .busy(b_l), .qs(s_l)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic d, input logic en,
                      input logic sy, input logic ak,
                      input logic cl, input logic rn);
    ds = d; shift_en = en; sync = sy;
    q_ack = ak; clr_ovr = cl; mr_n = rn;
    @(posedge cp);
    #1;
    ds = 1'b0; shift_en = 1'b0; sync = 1'b0;
    q_ack = 1'b0; clr_ovr = 1'b0; mr_n = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b,
                           input logic ack_last);
    for (int i = 7; i >= 0; i--)
      step(b[i], 1'b1, 1'b0, (i == 0) & ack_last, 1'b0, 1'b1);
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_q"}, {24'h0, q_m}, 32'h0);
    chk({tag, "_v"}, {31'h0, v_m}, 32'h0);
    chk({tag, "_ovr"}, {31'h0, o_m}, 32'h0);
    chk({tag, "_busy"}, {31'h0, b_m}, 32'h0);
    chk({tag, "_qs"}, {31'h0, s_m}, 32'h0);
    chk({tag, "_ql"}, {24'h0, q_l}, 32'h0);
  endtask

  initial begin
    logic [7:0] b;
    ds = 0; shift_en = 0; sync = 0;
    q_ack = 0; clr_ovr = 0; mr_n = 0;
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk_rst("reset");

    b = 8'hB2;
    for (int i = 7; i >= 0; i--) begin
      step(b[i], 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      chk($sformatf("b2_busy%0d", 7 - i), {31'h0, b_m},
          {31'h0, (i != 0)});
      if (i != 0) chk("b2_v_early", {31'h0, v_m}, 32'h0);
    end
    chk("b2_q", {24'h0, q_m}, 32'hB2);
    chk("b2_v", {31'h0, v_m}, 32'h1);
    chk("4d_q", {24'h0, q_l}, 32'h4D);
    chk("4d_v", {31'h0, v_l}, 32'h1);

    b = 8'hFF;
    for (int i = 7; i >= 0; i--) begin
      step(b[i], 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      if (i == 7) chk("qs_b7", {31'h0, s_m}, 32'h1);
      if (i == 6) chk("qs_b6", {31'h0, s_m}, 32'h0);
      if (i == 7) chk("qs_l0", {31'h0, s_l}, 32'h1);
    end
    chk("ovr_q", {24'h0, q_m}, 32'hB2);
    chk("ovr_set", {31'h0, o_m}, 32'h1);
    chk("ovr_v", {31'h0, v_m}, 32'h1);
    chk("ovr_ql", {24'h0, q_l}, 32'h4D);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("ovr_clr", {31'h0, o_m}, 32'h0);
    chk("ovr_clr_v", {31'h0, v_m}, 32'h1);

    send_byte(8'hFF, 1'b1);
    chk("ackc_q", {24'h0, q_m}, 32'hFF);
    chk("ackc_v", {31'h0, v_m}, 32'h1);
    chk("ackc_ovr", {31'h0, o_m}, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("ack_v", {31'h0, v_m}, 32'h0);
    chk("ack_q", {24'h0, q_m}, 32'hFF);

    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("sync_busy", {31'h0, b_m}, 32'h1);
    b = 8'h01;
    for (int i = 6; i >= 0; i--)
      step(b[i], 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("sync_q", {24'h0, q_m}, 32'h01);
    chk("sync_v", {31'h0, v_m}, 32'h1);
    chk("sync_ql", {24'h0, q_l}, 32'h80);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

    b = 8'hA5;
    for (int i = 7; i >= 0; i--) begin
      step(b[i], 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      if (i != 0) begin
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        if (i == 1) begin
          chk("gap_busy", {31'h0, b_m}, 32'h1);
          chk("gap_v", {31'h0, v_m}, 32'h0);
        end
      end
    end
    chk("gap_q", {24'h0, q_m}, 32'hA5);
    chk("gap_v_done", {31'h0, v_m}, 32'h1);

    send_byte(8'hFF, 1'b0);
    chk("ovr2_set", {31'h0, o_m}, 32'h1);
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("mid_busy", {31'h0, b_m}, 32'h1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_rst("mid_rst");

    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("sync_idle", {31'h0, b_m}, 32'h0);
    send_byte(8'h3C, 1'b0);
    chk("3c_q", {24'h0, q_m}, 32'h3C);
    chk("3c_v", {31'h0, v_m}, 32'h1);
    chk("3c_ql", {24'h0, q_l}, 32'h3C);
    chk("3c_busy", {31'h0, b_m}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
